// File: rtl/gearbox_in_w_to_out_w.sv
// gearbox_in_w_to_out_w
// Width-conversion gearbox: packs a stream of IN_W-bit words into OUT_W-bit
// words, LSB-first, through a BUF_W-bit accumulator. Bit 0 of the accumulator
// is always the oldest buffered bit; bits at and above the fill count are zero.
// Ready/valid on both sides, a fill-level output and a synchronous flush.
module gearbox_in_w_to_out_w #(
   parameter int IN_W  = 10,
   parameter int OUT_W = 8,
   parameter int BUF_W = 32,
   // derived from BUF_W; not meant to be overridden
   parameter int CNT_W = $clog2(BUF_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] fill
);

   // Elaboration-time sanity of the geometry: the buffer must hold a full
   // output word plus a full input word so push and pop can overlap.
   if (IN_W < 1) begin : g_bad_in_w
      $error("gearbox_in_w_to_out_w: IN_W must be >= 1");
   end
   if (OUT_W < 1) begin : g_bad_out_w
      $error("gearbox_in_w_to_out_w: OUT_W must be >= 1");
   end
   if (BUF_W < IN_W + OUT_W) begin : g_bad_buf_w
      $error("gearbox_in_w_to_out_w: BUF_W must be >= IN_W + OUT_W");
   end

   // Count-domain constants; all count arithmetic is done at CNT_W bits.
   localparam logic [CNT_W-1:0] IN_STEP  = CNT_W'(IN_W);
   localparam logic [CNT_W-1:0] OUT_STEP = CNT_W'(OUT_W);
   localparam logic [CNT_W-1:0] IN_LIMIT = CNT_W'(BUF_W - IN_W);

   logic [BUF_W-1:0] buf_r;
   logic [CNT_W-1:0] cnt_r;

   logic [BUF_W-1:0] in_ext_s;
   logic [BUF_W-1:0] kept_s;
   logic [BUF_W-1:0] ins_s;
   logic [BUF_W-1:0] buf_next_s;
   logic [CNT_W-1:0] base_s;
   logic [CNT_W-1:0] cnt_next_s;
   logic             push_s;
   logic             pop_s;

   // Output word and fill level come straight from registers.
   assign out_data = buf_r[OUT_W-1:0];
   assign fill     = cnt_r;

   // Incoming word zero-extended to the accumulator width before placement.
   assign in_ext_s = {{(BUF_W - IN_W){1'b0}}, in_data};

   // Handshake levels depend only on the registered count; flush masks both
   // sides so no transfer can coincide with the discard.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      if (flush) begin
         in_ready  = 1'b0;
         out_valid = 1'b0;
      end else begin
         in_ready  = (cnt_r <= IN_LIMIT);
         out_valid = (cnt_r >= OUT_STEP);
      end
   end

   assign push_s = in_valid & in_ready;
   assign pop_s  = out_valid & out_ready;

   // Drop the popped word first, then land the new word directly above the
   // bits that remain, so a simultaneous push and pop stays in bit order.
   always_comb begin
      kept_s     = buf_r;
      base_s     = cnt_r;
      ins_s      = {BUF_W{1'b0}};
      buf_next_s = buf_r;
      cnt_next_s = cnt_r;
      if (pop_s) begin
         kept_s = buf_r >> OUT_W;
         base_s = cnt_r - OUT_STEP;
      end else begin
         kept_s = buf_r;
         base_s = cnt_r;
      end
      if (push_s) begin
         ins_s      = in_ext_s << base_s;
         cnt_next_s = base_s + IN_STEP;
      end else begin
         ins_s      = {BUF_W{1'b0}};
         cnt_next_s = base_s;
      end
      buf_next_s = kept_s | ins_s;
   end

   // Accumulator and fill count; flush empties both on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_r <= {BUF_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
      end else if (flush) begin
         buf_r <= {BUF_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         buf_r <= buf_next_s;
         cnt_r <= cnt_next_s;
      end
   end

endmodule

// File: tb/tb_gearbox_in_w_to_out_w.sv
// Bench for gearbox_in_w_to_out_w: directed cases on a default-sized instance
// plus randomized traffic on three other geometries. Expected output words are
// built by a bit-queue reference model and compared by separate monitors.
module tb_gearbox_in_w_to_out_w;

   logic clk;
   logic rst_n;
   logic sw_rst_n;
   logic flush;
   logic in_valid;
   logic in_ready;
   logic [9:0] in_data;
   logic out_valid;
   logic out_ready;
   logic [7:0] out_data;
   logic [5:0] fill;

   int checks;
   int failures;

   // expected bit stream and expected words for the default instance
   bit         u0_bq[$];
   logic [7:0] u0_eq[$];

   logic [7:0] t1_exp [5] = '{8'h01, 8'h08, 8'h30, 8'h00, 8'h01};
   logic [7:0] got[$];

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   gearbox_in_w_to_out_w u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .fill(fill)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // reference model for the default instance: accepted words become bits,
   // every OUT_W collected bits become one expected word
   always @(negedge clk) begin : u0_sb_in
      logic [7:0] w;
      if (!rst_n || flush) begin
         u0_bq.delete();
         u0_eq.delete();
      end else if (in_valid && in_ready) begin
         for (int k = 0; k < 10; k++) u0_bq.push_back(in_data[k]);
         while (u0_bq.size() >= 8) begin
            for (int k = 0; k < 8; k++) w[k] = u0_bq.pop_front();
            u0_eq.push_back(w);
         end
      end
   end

   // monitor for the default instance: every popped word must match the model
   always @(negedge clk) begin : u0_sb_out
      if (rst_n && out_valid && out_ready) begin
         if (u0_eq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL u0_unexpected_word: got 0x%0h expected none", out_data);
         end else begin
            check("u0_word", 128'(out_data), 128'(u0_eq.pop_front()));
         end
      end
   end

   // parameter sweep instances with random valid/ready
   for (genvar g = 0; g < 3; g++) begin : sw
      localparam int IW = (g == 0) ? 8  : ((g == 1) ? 66  : 10);
      localparam int OW = (g == 0) ? 10 : ((g == 1) ? 64  : 8);
      localparam int BW = (g == 0) ? 32 : ((g == 1) ? 160 : 18);
      localparam int CW = $clog2(BW + 1);

      logic          s_in_valid;
      logic          s_in_ready;
      logic [IW-1:0] s_in_data;
      logic          s_out_valid;
      logic          s_out_ready;
      logic [OW-1:0] s_out_data;
      logic [CW-1:0] s_fill;
      logic          done;
      bit            bq[$];
      logic [OW-1:0] eq[$];

      gearbox_in_w_to_out_w #(.IN_W(IW), .OUT_W(OW), .BUF_W(BW)) u_dut (
         .clk(clk), .rst_n(sw_rst_n), .flush(1'b0),
         .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
         .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
         .fill(s_fill)
      );

      // reference model: bit queue regrouped into OW-bit expected words
      always @(negedge clk) begin : sb_in
         logic [OW-1:0] w;
         if (!sw_rst_n) begin
            bq.delete();
            eq.delete();
         end else if (s_in_valid && s_in_ready) begin
            for (int k = 0; k < IW; k++) bq.push_back(s_in_data[k]);
            while (bq.size() >= OW) begin
               for (int k = 0; k < OW; k++) w[k] = bq.pop_front();
               eq.push_back(w);
            end
         end
      end

      // monitor: compare each popped word against the model
      always @(negedge clk) begin : sb_out
         if (sw_rst_n && s_out_valid && s_out_ready) begin
            if (eq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sw%0d_unexpected_word: got 0x%0h expected none", g, s_out_data);
            end else begin
               check($sformatf("sw%0d_word", g), 128'(s_out_data), 128'(eq.pop_front()));
            end
         end
      end

      // random stimulus, then drain and compare the leftover residue
      initial begin
         done        = 1'b0;
         s_in_valid  = 1'b0;
         s_out_ready = 1'b0;
         s_in_data   = '0;
         wait (sw_rst_n === 1'b1);
         nxt();
         for (int c = 0; c < 600; c++) begin
            s_in_valid  = ($urandom_range(0, 3) != 0);
            s_in_data   = IW'({$urandom, $urandom, $urandom});
            s_out_ready = ($urandom_range(0, 3) != 0);
            nxt();
         end
         s_in_valid  = 1'b0;
         s_out_ready = 1'b1;
         for (int c = 0; c < 40; c++) begin
            if (int'(s_fill) < OW) break;
            nxt();
         end
         @(negedge clk);
         check($sformatf("sw%0d_drained", g), 128'(eq.size()), 128'(0));
         check($sformatf("sw%0d_residue", g), 128'(s_fill), 128'(bq.size()));
         done = 1'b1;
      end
   end

   // directed cases and random traffic on the default instance
   initial begin : main
      logic [9:0] a;
      logic [9:0] b;
      logic [9:0] c;
      logic       all_done;
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      sw_rst_n  = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = 10'd0;
      #3;
      check("reset_fill", fill, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_in_ready", in_ready, 1);
      nxt();
      nxt();
      rst_n    = 1'b1;
      sw_rst_n = 1'b1;

      // 1: four consecutive pushes with the consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = (i < 4);
         in_data  = 10'(i + 1);
         @(negedge clk);
         if (i == 0) check("t1_valid_before_push", out_valid, 0);
         if (i == 1) check("t1_first_valid", out_valid, 1);
         if (out_valid) got.push_back(out_data);
         nxt();
      end
      check("t1_word_count", got.size(), 5);
      for (int k = 0; k < 5; k++) begin
         if (k < got.size()) check($sformatf("t1_word%0d", k), got[k], t1_exp[k]);
      end
      @(negedge clk);
      check("t1_fill_end", fill, 0);
      nxt();

      // 2: backpressure fills to 30 and stalls the producer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 10'($urandom);
         @(negedge clk);
         if (i >= 3) check("t2_in_ready_low", in_ready, 0);
         nxt();
      end
      @(negedge clk);
      check("t2_fill_full", fill, 30);
      out_ready = 1'b1;
      nxt();
      @(negedge clk);
      check("t2_fill_one_pop", fill, 22);
      check("t2_in_ready_back", in_ready, 1);
      nxt();
      @(negedge clk);
      check("t2_fill_push_pop", fill, 24);
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (fill < 6'd8) break;
         nxt();
      end
      @(negedge clk);
      check("t2_fill_drained", fill, 0);
      nxt();

      // 3: simultaneous push and pop at a fill of 12
      a = 10'($urandom);
      b = 10'($urandom);
      c = 10'($urandom);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = a;
      nxt();
      in_data = b;
      nxt();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      nxt();
      @(negedge clk);
      check("t3_fill_12", fill, 12);
      in_valid = 1'b1;
      in_data  = c;
      nxt();
      in_valid = 1'b0;
      @(negedge clk);
      check("t3_fill_14", fill, 14);
      check("t3_low_byte", out_data, {c[3:0], b[9:6]});
      nxt();
      @(negedge clk);
      check("t3_fill_6", fill, 6);
      check("t3_no_partial", out_valid, 0);
      check("t3_residue_bits", out_data, {2'b00, c[9:4]});
      flush = 1'b1;
      nxt();
      flush = 1'b0;

      // 4: flush discards a buffered word
      in_valid = 1'b1;
      in_data  = 10'h155;
      nxt();
      in_valid = 1'b0;
      flush    = 1'b1;
      @(negedge clk);
      check("t4_flush_in_ready", in_ready, 0);
      check("t4_flush_out_valid", out_valid, 0);
      nxt();
      flush = 1'b0;
      @(negedge clk);
      check("t4_fill_after_flush", fill, 0);
      check("t4_valid_after_flush", out_valid, 0);
      in_valid = 1'b1;
      in_data  = 10'h2AA;
      nxt();
      in_valid = 1'b0;
      @(negedge clk);
      check("t4_first_word", out_data, 8'hAA);
      check("t4_first_valid", out_valid, 1);
      nxt();
      nxt();
      nxt();
      @(negedge clk);
      check("t4_residue_held", fill, 2);
      check("t4_residue_no_valid", out_valid, 0);
      flush = 1'b1;
      nxt();
      flush = 1'b0;

      // 5: asynchronous reset mid-cycle with 18 bits buffered
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 10'($urandom);
         nxt();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("t5_fill_18", fill, 18);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_fill", fill, 0);
      check("t5_async_out_valid", out_valid, 0);
      check("t5_async_out_data", out_data, 0);
      check("t5_async_in_ready", in_ready, 1);
      nxt();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 10'h0A5;
      nxt();
      in_valid = 1'b0;
      @(negedge clk);
      check("t5_aligned_after_reset", out_data, 8'hA5);
      nxt();
      flush = 1'b1;
      nxt();
      flush = 1'b0;

      // 6: random traffic with occasional flush, then drain
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 10'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         nxt();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (fill < 6'd8) break;
         nxt();
      end
      @(negedge clk);
      check("rnd_drained", u0_eq.size(), 0);
      check("rnd_residue", fill, u0_bq.size());

      // wait for the sweep instances with a bounded budget
      all_done = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         all_done = sw[0].done & sw[1].done & sw[2].done;
         if (all_done) break;
         nxt();
      end
      check("sweep_done", all_done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gearbox_in_w_to_out_w.md
# gearbox_in_w_to_out_w

Parametrised width-conversion gearbox for the serial link: packs a stream of IN_W-bit words into OUT_W-bit words, LSB-first, through a bit-accumulator buffer. It replaces the fixed 10-to-8 buffer and adds ready/valid handshakes on both sides, a fill-level output and a synchronous flush. It sits between the line encoder (IN_W producer) and the serializer (OUT_W consumer).

## Interface
- IN_W, 10, input word width in bits (>= 1)
- OUT_W, 8, output word width in bits (>= 1)
- BUF_W, 32, accumulator capacity in bits; elaboration error unless BUF_W >= IN_W + OUT_W
- CNT_W, $clog2(BUF_W+1), fill counter width (derived, not overridden)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous discard of all buffered bits
- in_valid  in  1  in_data valid
- in_ready  out  1  gearbox can accept IN_W bits this cycle
- in_data  in  IN_W  input word; bit 0 is the earliest bit
- out_valid  out  1  out_data holds OUT_W valid bits
- out_ready  in  1  consumer takes out_data this cycle
- out_data  out  OUT_W  output word; bit 0 is the earliest bit
- fill  out  CNT_W  number of valid bits currently buffered

## Operation
- State: buffer register buf[BUF_W-1:0] and counter cnt (0..BUF_W). Valid bits are buf[cnt-1:0]; buf[0] is the oldest bit. Bits at and above cnt are held at zero.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !flush & (cnt <= BUF_W - IN_W). Depends on registered cnt only; no combinational path from out_ready.
- out_valid = !flush & (cnt >= OUT_W); out_data = buf[OUT_W-1:0]; fill = cnt.
- Per cycle, without flush: buf is shifted right by OUT_W if pop (zero-fill); then in_data is written at bit offset cnt - (pop ? OUT_W : 0) if push; cnt_next = cnt - pop*OUT_W + push*IN_W.
- Push and pop in the same cycle are both honoured; the new word lands directly above the bits that remain after the pop.
- flush: buf and cnt are cleared to 0 on the next edge. It overrides push and pop. Both handshake outputs are low while flush is high, so no transfer occurs in that cycle.
- Residue: fewer than OUT_W bits are held indefinitely until more input arrives or flush is asserted. Partial words are never emitted.
- No overflow or underflow is possible: the handshakes gate every transfer.

## Timing
- Reset (rst_n low, asynchronous): buf = 0, cnt = 0, fill = 0, out_valid = 0, out_data = 0, in_ready = 1.
- Latency: a bit accepted at edge N appears on out_data in cycle N+1 at the earliest, when it lies within the OUT_W oldest bits.
- Throughput: with BUF_W >= IN_W + OUT_W and out_ready held high, the output sustains one word per clock whenever the average input rate is OUT_W/IN_W words per clock (e.g. 8 of 10 clocks for 10 to 8).
- Backpressure: with out_ready low, cnt grows until cnt > BUF_W - IN_W, then in_ready drops. At defaults, in_ready is low for cnt >= 23.
- rst_n deasserted mid-stream: all buffered bits are lost. The first accepted word after reset is aligned at bit 0.

## Test plan
- Defaults, out_ready=1, push 0x001, 0x002, 0x003, 0x004 on consecutive clocks -> out_data sequence 0x01, 0x08, 0x30, 0x00, 0x01. The first out_valid appears 1 cycle after the first push. fill returns to 0.
- Defaults, out_ready=0, push continuously -> accepted words 0 to 2 give fill = 30; in_ready then drops and stays low. Raising out_ready drains one byte per clock.
- Simultaneous push and pop at cnt = 12 -> cnt_next = 14. The new word sits at bits [13:4] and the remaining 4 old bits are at [3:0].
- Push 0x155, then flush for one cycle -> next cycle fill = 0, out_valid = 0. A following push of 0x2AA yields out_data = 0xAA first.
- Assert rst_n low asynchronously mid-cycle with fill = 18 -> outputs take their reset values immediately, before any clock edge.
- Parameter sweep: (IN_W, OUT_W, BUF_W) = (8,10,32), (66,64,160), (10,8,18), with random valid/ready -> the output bit stream equals the input bit stream with nothing lost, duplicated or reordered, checked against a scoreboard.
